// File: rtl/alu_ctrl_pkg.sv
// ALU control sequencer: shared encodings and state type.
// Optional multiply/divide support is enabled by ALU_CTRL_MULDIV_EN.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;
    localparam logic [3:0] OP_NOP  = 4'b1110;
    localparam logic [3:0] OP_SLL  = 4'b1111;

    localparam logic [2:0] AOP_ADD   = 3'b000;
    localparam logic [2:0] AOP_SUB   = 3'b001;
    localparam logic [2:0] AOP_RTYPE = 3'b010;
    localparam logic [2:0] AOP_AND   = 3'b011;
    localparam logic [2:0] AOP_OR    = 3'b100;
    localparam logic [2:0] AOP_SLT   = 3'b101;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    typedef enum logic {
        IDLE    = 1'b0,
        MD_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/alu_ctrl_if.sv
// ALU control sequencer: request/response handshake bundle.
// master drives requests and consumes results; slave is the sequencer.
interface alu_ctrl_if #(
    parameter int ALUOP_W = 3,
    parameter int FUNCT_W = 6,
    parameter int OP_W    = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [ALUOP_W-1:0] alu_op;
    logic [FUNCT_W-1:0] funct;
    logic               out_valid;
    logic               out_ready;
    logic [OP_W-1:0]    op;
    logic               illegal;
    logic               md_start;
    logic               md_busy;

    modport master (
        output in_valid, alu_op, funct, out_ready,
        input  in_ready, out_valid, op, illegal, md_start, md_busy
    );

    modport slave (
        input  in_valid, alu_op, funct, out_ready,
        output in_ready, out_valid, op, illegal, md_start, md_busy
    );
endinterface

// File: rtl/alu_ctrl_dec.sv
// ALU control decode table: (alu_op, funct) -> op, illegal, is_md.
// MULT/DIV rows exist only when ALU_CTRL_MULDIV_EN is defined.
module alu_ctrl_dec
    import alu_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int FUNCT_W = 6,
    parameter int OP_W    = 4
) (
    input  logic [ALUOP_W-1:0] alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic [OP_W-1:0]    op,
    output logic               illegal,
    output logic               is_md
);

    // Pure table lookup; unmatched rows fall through to the NOP default.
    always_comb begin
        op      = OP_W'(OP_NOP);
        illegal = 1'b1;
        is_md   = 1'b0;
        case (alu_op)
            ALUOP_W'(AOP_ADD): begin
                op      = OP_W'(OP_ADD);
                illegal = 1'b0;
            end
            ALUOP_W'(AOP_SUB): begin
                op      = OP_W'(OP_SUB);
                illegal = 1'b0;
            end
            ALUOP_W'(AOP_AND): begin
                op      = OP_W'(OP_AND);
                illegal = 1'b0;
            end
            ALUOP_W'(AOP_OR): begin
                op      = OP_W'(OP_OR);
                illegal = 1'b0;
            end
            ALUOP_W'(AOP_SLT): begin
                op      = OP_W'(OP_SLT);
                illegal = 1'b0;
            end
            ALUOP_W'(AOP_RTYPE): begin
                case (funct)
                    FUNCT_W'(FN_ADD): begin
                        op      = OP_W'(OP_ADD);
                        illegal = 1'b0;
                    end
                    FUNCT_W'(FN_SUB): begin
                        op      = OP_W'(OP_SUB);
                        illegal = 1'b0;
                    end
                    FUNCT_W'(FN_AND): begin
                        op      = OP_W'(OP_AND);
                        illegal = 1'b0;
                    end
                    FUNCT_W'(FN_OR): begin
                        op      = OP_W'(OP_OR);
                        illegal = 1'b0;
                    end
                    FUNCT_W'(FN_SLT): begin
                        op      = OP_W'(OP_SLT);
                        illegal = 1'b0;
                    end
                    FUNCT_W'(FN_SLL): begin
                        op      = OP_W'(OP_SLL);
                        illegal = 1'b0;
                    end
`ifdef ALU_CTRL_MULDIV_EN
                    FUNCT_W'(FN_MULT): begin
                        op      = OP_W'(OP_MULT);
                        illegal = 1'b0;
                        is_md   = 1'b1;
                    end
                    FUNCT_W'(FN_DIV): begin
                        op      = OP_W'(OP_DIV);
                        illegal = 1'b0;
                        is_md   = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: registered decode with valid/ready handshake
// and an optional multiply/divide occupancy FSM (ALU_CTRL_MULDIV_EN).
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int ALUOP_W   = 3,
    parameter int FUNCT_W   = 6,
    parameter int OP_W      = 4,
    parameter int MD_CYCLES = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_ctrl_if.slave bus
);

    if (MD_CYCLES < 2 || MD_CYCLES > 255) begin : g_bad_md_cycles
        $error("MD_CYCLES must be within 2..255");
    end

    logic [OP_W-1:0] dec_op;
    logic            dec_ill;
    logic            dec_md;

    logic            out_valid_q;
    logic [OP_W-1:0] op_q;
    logic            ill_q;
    logic            idle;
    logic            beat;
    logic            accept;

    alu_ctrl_dec #(
        .ALUOP_W (ALUOP_W),
        .FUNCT_W (FUNCT_W),
        .OP_W    (OP_W)
    ) u_dec (
        .alu_op  (bus.alu_op),
        .funct   (bus.funct),
        .op      (dec_op),
        .illegal (dec_ill),
        .is_md   (dec_md)
    );

    assign beat         = out_valid_q & bus.out_ready;
    assign bus.in_ready = rst_n & idle & (~out_valid_q | bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.op        = op_q;
    assign bus.illegal   = ill_q;

    // Output register: load on accept, drop valid once the beat is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            op_q        <= OP_W'(OP_NOP);
            ill_q       <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            op_q        <= dec_op;
            ill_q       <= dec_ill;
        end else if (beat) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef ALU_CTRL_MULDIV_EN
    state_e     state;
    state_e     state_d;
    logic       md_q;
    logic [7:0] cnt;

    assign bus.md_start = md_q & out_valid_q;

    // Multiply/divide flag travels with the registered beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_q <= 1'b0;
        end else if (accept) begin
            md_q <= dec_md;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state: enter on an md beat handshake, leave after count hits 0.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (beat && md_q) state_d = MD_WAIT;
            MD_WAIT: if (cnt == 8'd0)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-derived outputs.
    always_comb begin
        idle        = (state == IDLE);
        bus.md_busy = (state == MD_WAIT);
    end

    // Occupancy counter: load on entry, count down while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (state == IDLE && state_d == MD_WAIT) begin
            cnt <= 8'(MD_CYCLES - 1);
        end else if (state == MD_WAIT && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end
`else
    logic md_unused;

    assign md_unused    = dec_md;
    assign idle         = ~md_unused;
    assign bus.md_start = 1'b0;
    assign bus.md_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq (directed + random vs model).
// Expectations follow the ALU_CTRL_MULDIV_EN setting of the build.
`timescale 1ns/1ps
module tb_alu_ctrl_seq;
    import alu_ctrl_pkg::*;

`ifdef ALU_CTRL_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif
    localparam int MDC = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    alu_ctrl_if #(.ALUOP_W(3), .FUNCT_W(6), .OP_W(4)) bus ();

    alu_ctrl_seq #(
        .ALUOP_W   (3),
        .FUNCT_W   (6),
        .OP_W      (4),
        .MD_CYCLES (MDC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] a, input logic [5:0] f);
        bus.in_valid  = 1'b1;
        bus.alu_op    = a;
        bus.funct     = f;
        bus.out_ready = 1'b1;
    endtask

    // Reference decode from the op table: returns {is_md, illegal, op}.
    function automatic logic [5:0] ref_dec(input logic [2:0] a,
                                           input logic [5:0] f);
        logic [3:0] o;
        logic       il;
        logic       m;
        o  = 4'b1110;
        il = 1'b1;
        m  = 1'b0;
        if (a == 3'b000) begin o = 4'b0010; il = 1'b0; end
        if (a == 3'b001) begin o = 4'b0110; il = 1'b0; end
        if (a == 3'b011) begin o = 4'b0000; il = 1'b0; end
        if (a == 3'b100) begin o = 4'b0001; il = 1'b0; end
        if (a == 3'b101) begin o = 4'b0111; il = 1'b0; end
        if (a == 3'b010) begin
            if (f == 6'b100000) begin o = 4'b0010; il = 1'b0; end
            if (f == 6'b100010) begin o = 4'b0110; il = 1'b0; end
            if (f == 6'b100100) begin o = 4'b0000; il = 1'b0; end
            if (f == 6'b100101) begin o = 4'b0001; il = 1'b0; end
            if (f == 6'b101010) begin o = 4'b0111; il = 1'b0; end
            if (f == 6'b000000) begin o = 4'b1111; il = 1'b0; end
            if (MD && f == 6'b011000) begin o = 4'b1000; il = 1'b0; m = 1'b1; end
            if (MD && f == 6'b011010) begin o = 4'b1001; il = 1'b0; m = 1'b1; end
        end
        return {m, il, o};
    endfunction

    logic [2:0] b2b_aop [3];
    logic [3:0] b2b_op  [3];
    logic [5:0] fn_pool [12];

    // Model state for the random phase.
    logic       m_valid;
    logic [3:0] m_op;
    logic       m_ill;
    logic       m_md;
    int         m_busy;

    initial begin
        int         nbusy;
        logic       p_rdy;
        logic       nb_beat;
        logic       nb_acc;
        logic [5:0] r;

        b2b_aop = '{3'b000, 3'b100, 3'b101};
        b2b_op  = '{4'b0010, 4'b0001, 4'b0111};
        fn_pool = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                    6'b101010, 6'b000000, 6'b011000, 6'b011010,
                    6'b011000, 6'b011010, 6'b111111, 6'b000001};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.alu_op    = '0;
        bus.funct     = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_op", bus.op, 4'b1110);
        chk("rst_illegal", bus.illegal, 1'b0);
        chk("rst_md_start", bus.md_start, 1'b0);
        chk("rst_md_busy", bus.md_busy, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        #2 rst_n = 1'b1;
        #1 chk("rel_in_ready", bus.in_ready, 1'b1);

        // SUB via R-type funct, one-cycle latency.
        send(3'b010, 6'b100010);
        tick();
        chk("sub_valid", bus.out_valid, 1'b1);
        chk("sub_op", bus.op, 4'b0110);
        chk("sub_ill", bus.illegal, 1'b0);

        // Illegal combinations.
        send(3'b010, 6'b111111);
        tick();
        chk("badfn_op", bus.op, 4'b1110);
        chk("badfn_ill", bus.illegal, 1'b1);
        send(3'b111, 6'b100000);
        tick();
        chk("badop_op", bus.op, 4'b1110);
        chk("badop_ill", bus.illegal, 1'b1);

        // Back-to-back ADD, OR, SLT at full throughput.
        for (int k = 0; k < 3; k++) begin
            send(b2b_aop[k], 6'b000000);
            tick();
            chk("b2b_valid", bus.out_valid, 1'b1);
            chk("b2b_op", bus.op, b2b_op[k]);
            chk("b2b_in_ready", bus.in_ready, 1'b1);
        end

        // AND beat stalled for 3 cycles.
        send(3'b011, 6'b000000);
        tick();
        bus.alu_op    = 3'b000;
        bus.out_ready = 1'b0;
        #1 chk("stall_in_ready0", bus.in_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_op", bus.op, 4'b0000);
            chk("stall_valid", bus.out_valid, 1'b1);
            chk("stall_in_ready", bus.in_ready, 1'b0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1 chk("unstall_in_ready", bus.in_ready, 1'b1);
        tick();
        chk("unstall_drain", bus.out_valid, 1'b0);

        // MULT occupancy.
        send(3'b010, 6'b011000);
        tick();
        chk("mult_md_start", bus.md_start, MD);
        chk("mult_ill", bus.illegal, !MD);
        chk("mult_op", bus.op, MD ? 4'b1000 : 4'b1110);
        bus.in_valid = 1'b0;
        nbusy = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.md_busy) nbusy++;
            chk("md_busy", bus.md_busy, MD && c < MDC);
            chk("md_in_ready", bus.in_ready, !(MD && c < MDC));
        end
        chk("md_busy_count", nbusy, MD ? MDC : 0);

        // Reset pulled in the second MD_WAIT cycle with an ADD beat pending.
        send(3'b010, 6'b011010);
        tick();
        chk("div_md_start", bus.md_start, MD);
        send(3'b000, 6'b000000);
        tick();
        chk("mdw_op", bus.op, 4'b0010);
        chk("mdw_busy1", bus.md_busy, MD);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        chk("mdw_busy2", bus.md_busy, MD);
        chk("mdw_valid", bus.out_valid, 1'b1);
        chk("mdw_in_ready", bus.in_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.md_busy, 1'b0);
        chk("arst_valid", bus.out_valid, 1'b0);
        chk("arst_op", bus.op, 4'b1110);
        chk("arst_in_ready", bus.in_ready, 1'b0);
        #2 rst_n = 1'b1;
        #1 chk("arst_rel_ready", bus.in_ready, 1'b1);

        // Random phase against the behavioural model.
        bus.out_ready = 1'b1;
        tick();
        m_valid = 1'b0;
        m_op    = 4'b1110;
        m_ill   = 1'b0;
        m_md    = 1'b0;
        m_busy  = 0;
        for (int i = 0; i < 600; i++) begin
            chk("rnd_valid", bus.out_valid, m_valid);
            chk("rnd_busy", bus.md_busy, m_busy > 0);
            chk("rnd_md_start", bus.md_start, m_valid && m_md);
            if (m_valid) begin
                chk("rnd_op", bus.op, m_op);
                chk("rnd_ill", bus.illegal, m_ill);
            end
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.alu_op    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0)
                bus.funct = 6'($urandom);
            else
                bus.funct = fn_pool[$urandom_range(0, 11)];
            p_rdy = (m_busy == 0) && (!m_valid || bus.out_ready);
            #1 chk("rnd_in_ready", bus.in_ready, p_rdy);
            nb_beat = m_valid && bus.out_ready;
            nb_acc  = bus.in_valid && p_rdy;
            r = ref_dec(bus.alu_op, bus.funct);
            tick();
            if (m_busy > 0)
                m_busy = m_busy - 1;
            else if (nb_beat && m_md)
                m_busy = MDC;
            if (nb_acc) begin
                m_valid = 1'b1;
                m_op    = r[3:0];
                m_ill   = r[4];
                m_md    = r[5];
            end else if (nb_beat) begin
                m_valid = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
